// File: rtl/multicycle_cpu_if.sv
// Shared instruction/data memory port: one request at a time, completed by req && ready.
interface multicycle_cpu_if #(
    parameter int unsigned n = 32
);
    logic         mem_req;
    logic         mem_we;
    logic [n-1:0] mem_addr;
    logic [n-1:0] mem_wdata;
    logic [n-1:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// with a sticky TRAP state for illegal opcodes and misaligned loads/stores.
module multicycle_cpu #(
    parameter int unsigned  n        = 32,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_cpu_if.master mem,
    output logic [n-1:0]     pc,
    output logic             retire,
    output logic             trap
);
    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;
    typedef enum logic [3:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpAddi, OpLw, OpSw, OpBeq, OpJ, OpIll
    } op_e;

    state_e       state_q, state_d;
    op_e          op;
    logic [31:0]  ir_q;
    logic [n-1:0] pc_q, pc_d, pcnext_q, a_q, b_q, aluout_q, mdr_q;
    logic [n-1:0] rf_q [32];
    logic [n-1:0] sext_imm, alu_res, wb_data;
    logic [4:0]   wb_addr;

    assign sext_imm = {{(n-16){ir_q[15]}}, ir_q[15:0]};
    assign wb_addr  = (ir_q[31:26] == 6'h00) ? ir_q[15:11] : ir_q[20:16];
    assign wb_data  = (op == OpLw) ? mdr_q : aluout_q;
    assign pc       = pc_q;

    always_comb begin
        op = OpIll;
        unique case (ir_q[31:26])
            6'h00: begin
                unique case (ir_q[5:0])
                    6'h20:   op = OpAdd;
                    6'h22:   op = OpSub;
                    6'h24:   op = OpAnd;
                    6'h25:   op = OpOr;
                    6'h2A:   op = OpSlt;
                    default: op = OpIll;
                endcase
            end
            6'h08:   op = OpAddi;
            6'h23:   op = OpLw;
            6'h2B:   op = OpSw;
            6'h04:   op = OpBeq;
            6'h02:   op = OpJ;
            default: op = OpIll;
        endcase
    end

    // Default result is A + sext(imm), shared by addi and the lw/sw address.
    always_comb begin
        alu_res = a_q + sext_imm;
        case (op)
            OpAdd:   alu_res = a_q + b_q;
            OpSub:   alu_res = a_q - b_q;
            OpAnd:   alu_res = a_q & b_q;
            OpOr:    alu_res = a_q | b_q;
            OpSlt:   alu_res = {{(n-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (mem.mem_ready) state_d = StDecode;
            StDecode: begin
                if (op == OpJ)        state_d = StFetch;
                else if (op == OpIll) state_d = StTrap;
                else                  state_d = StExec;
            end
            StExec: begin
                case (op)
                    OpLw, OpSw: state_d = (alu_res[1:0] != 2'b00) ? StTrap : StMem;
                    OpBeq:      state_d = StFetch;
                    default:    state_d = StWb;
                endcase
            end
            StMem:    if (mem.mem_ready) state_d = (op == OpSw) ? StFetch : StWb;
            StWb:     state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch;
        endcase
    end

    // Everything is gated by reset so the port stays quiet while reset is held.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = pc_q;
        mem.mem_wdata = b_q;
        retire        = 1'b0;
        trap          = 1'b0;
        pc_d          = pcnext_q;
        if (reset) begin
            unique case (state_q)
                StFetch:  mem.mem_req = 1'b1;
                StDecode: begin
                    if (op == OpJ) begin
                        retire = 1'b1;
                        pc_d   = {pcnext_q[n-1:28], ir_q[25:0], 2'b00};
                    end
                end
                StExec: begin
                    if (op == OpBeq) begin
                        retire = 1'b1;
                        if (a_q == b_q) pc_d = pcnext_q + {sext_imm[n-3:0], 2'b00};
                    end
                end
                StMem: begin
                    mem.mem_req  = 1'b1;
                    mem.mem_we   = (op == OpSw);
                    mem.mem_addr = aluout_q;
                    retire       = mem.mem_ready && (op == OpSw);
                end
                StWb:     retire = 1'b1;
                StTrap:   trap = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            pcnext_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            if (retire) pc_q <= pc_d;
            if (state_q == StFetch && mem.mem_ready) begin
                ir_q     <= mem.mem_rdata[31:0];
                pcnext_q <= pc_q + n'(4);
            end
            if (state_q == StDecode) begin
                a_q <= rf_q[ir_q[25:21]];
                b_q <= rf_q[ir_q[20:16]];
            end
            if (state_q == StExec) aluout_q <= alu_res;
            if (state_q == StMem && mem.mem_ready) mdr_q <= mem.mem_rdata;
            if (state_q == StWb && wb_addr != 5'd0) rf_q[wb_addr] <= wb_data;
        end
    end
endmodule
